// File: rtl/gba_bus_arbiter_if.sv
// Shared system bus bundle between the CPU, the DMA channels, the arbiter and mem_top.
// The master side drives requests and bus_pause; the slave side is the arbiter.
interface gba_bus_arbiter_if #(
  parameter int unsigned NUM_CH = 4
) ();
  logic [31:0]          cpu_addr;
  logic [31:0]          cpu_wdata;
  logic [1:0]           cpu_size;
  logic                 cpu_write;
  logic                 cpu_preemptable;
  logic [NUM_CH-1:0]    dma_req;
  logic [NUM_CH-1:0]    dma_yield;
  logic [32*NUM_CH-1:0] dma_addr;
  logic [32*NUM_CH-1:0] dma_wdata;
  logic [2*NUM_CH-1:0]  dma_size;
  logic [NUM_CH-1:0]    dma_write;
  logic                 bus_pause;
  logic [31:0]          bus_addr;
  logic [31:0]          bus_wdata;
  logic [1:0]           bus_size;
  logic                 bus_write;
  logic [NUM_CH-1:0]    dma_gnt;
  logic                 dmaActive;

  modport master (
    output cpu_addr, cpu_wdata, cpu_size, cpu_write, cpu_preemptable,
    output dma_req, dma_yield, dma_addr, dma_wdata, dma_size, dma_write, bus_pause,
    input  bus_addr, bus_wdata, bus_size, bus_write, dma_gnt, dmaActive
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_size, cpu_write, cpu_preemptable,
    input  dma_req, dma_yield, dma_addr, dma_wdata, dma_size, dma_write, bus_pause,
    output bus_addr, bus_wdata, bus_size, bus_write, dma_gnt, dmaActive
  );
endinterface

// File: rtl/gba_bus_arbiter.sv
// Fixed-priority owner of the shared system bus: CPU or one of NUM_CH DMA channels.
// Ownership only moves at CPU instruction boundaries, DMA unit boundaries and unpaused cycles.
module gba_bus_arbiter #(
  parameter int unsigned NUM_CH = 4
) (
  input logic             clock,
  input logic             reset,
  gba_bus_arbiter_if.slave sys
);
  localparam int unsigned OwnerW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {StCpuOwn, StHandoff, StDmaOwn, StReturn} state_e;

  state_e            state_q;
  logic [OwnerW-1:0] owner_q;
  logic [NUM_CH-1:0] gnt_q;
  logic              active_q;

  logic [OwnerW-1:0] top_idx;
  logic [NUM_CH-1:0] top_onehot;
  logic              any_req;
  logic              higher_req;
  logic [31:0]       own_addr;
  logic [31:0]       own_wdata;
  logic [1:0]        own_size;
  logic              own_write;
  logic              own_req;
  logic              own_yield;

  // Lowest requesting index wins; higher_req flags a requester that outranks the owner.
  always_comb begin
    top_idx    = '0;
    higher_req = 1'b0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (sys.dma_req[i]) top_idx = OwnerW'(i);
    end
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (sys.dma_req[i] && (OwnerW'(i) < owner_q)) higher_req = 1'b1;
    end
  end

  assign any_req    = |sys.dma_req;
  assign top_onehot = NUM_CH'(1) << top_idx;

  assign own_addr  = sys.dma_addr[32*int'(owner_q) +: 32];
  assign own_wdata = sys.dma_wdata[32*int'(owner_q) +: 32];
  assign own_size  = sys.dma_size[2*int'(owner_q) +: 2];
  assign own_write = sys.dma_write[owner_q];
  assign own_req   = sys.dma_req[owner_q];
  assign own_yield = sys.dma_yield[owner_q];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StCpuOwn;
      owner_q  <= '0;
      gnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      unique case (state_q)
        StCpuOwn: begin
          if (any_req && sys.cpu_preemptable && !sys.bus_pause) begin
            state_q  <= StHandoff;
            owner_q  <= top_idx;
            gnt_q    <= top_onehot;
            active_q <= 1'b1;
          end
        end
        StHandoff: state_q <= StDmaOwn;
        StDmaOwn: begin
          // Release outranks a simultaneous yield.
          if (!sys.bus_pause) begin
            if (!own_req) begin
              state_q <= StReturn;
              gnt_q   <= '0;
            end else if (own_yield && higher_req) begin
              state_q <= StHandoff;
              owner_q <= top_idx;
              gnt_q   <= top_onehot;
            end
          end
        end
        StReturn: begin
          if (any_req && !sys.bus_pause) begin
            state_q <= StHandoff;
            owner_q <= top_idx;
            gnt_q   <= top_onehot;
          end else begin
            state_q  <= StCpuOwn;
            active_q <= 1'b0;
          end
        end
        default: state_q <= StCpuOwn;
      endcase
    end
  end

  // Transition cycles present the incoming owner's address with the write strobe masked.
  always_comb begin
    sys.bus_addr  = sys.cpu_addr;
    sys.bus_wdata = sys.cpu_wdata;
    sys.bus_size  = sys.cpu_size;
    sys.bus_write = sys.cpu_write;
    unique case (state_q)
      StCpuOwn: ;
      StHandoff: begin
        sys.bus_addr  = own_addr;
        sys.bus_wdata = own_wdata;
        sys.bus_size  = own_size;
        sys.bus_write = 1'b0;
      end
      StDmaOwn: begin
        sys.bus_addr  = own_addr;
        sys.bus_wdata = own_wdata;
        sys.bus_size  = own_size;
        sys.bus_write = own_write;
      end
      StReturn: sys.bus_write = 1'b0;
      default: ;
    endcase
  end

  assign sys.dma_gnt   = gnt_q;
  assign sys.dmaActive = active_q;
endmodule

// File: tb/tb_gba_bus_arbiter.sv
// Bench for gba_bus_arbiter: directed scenarios plus random traffic against an ownership model.
module tb_gba_bus_arbiter;
  localparam int unsigned NUM_CH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  gba_bus_arbiter_if #(.NUM_CH(NUM_CH)) sys ();

  gba_bus_arbiter #(.NUM_CH(NUM_CH)) dut (
    .clock(clock),
    .reset(reset),
    .sys  (sys)
  );

  int checks = 0;
  int errors = 0;

  // Model: own is the granted channel (-1 = none); ho/rt mark the one-cycle transitions.
  int own = -1;
  bit ho  = 1'b0;
  bit rt  = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [NUM_CH-1:0] r);
    for (int i = 0; i < int'(NUM_CH); i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    int top;
    top = lowest(sys.dma_req);
    if (reset) begin
      own = -1; ho = 1'b0; rt = 1'b0;
    end else if (ho) begin
      ho = 1'b0;
    end else if (rt) begin
      rt = 1'b0;
      if (top >= 0 && !sys.bus_pause) begin own = top; ho = 1'b1; end
    end else if (own < 0) begin
      if (top >= 0 && sys.cpu_preemptable && !sys.bus_pause) begin own = top; ho = 1'b1; end
    end else if (!sys.bus_pause) begin
      if (!sys.dma_req[own]) begin own = -1; rt = 1'b1; end
      else if (sys.dma_yield[own] && top < own) begin own = top; ho = 1'b1; end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic check_model();
    logic [31:0] e_addr, e_wdata;
    logic [1:0]  e_size;
    logic        e_write;
    logic [NUM_CH-1:0] e_gnt;
    #1;
    e_addr = sys.cpu_addr; e_wdata = sys.cpu_wdata; e_size = sys.cpu_size;
    e_write = sys.cpu_write; e_gnt = '0;
    if (own >= 0) begin
      e_addr  = sys.dma_addr[own*32 +: 32];
      e_wdata = sys.dma_wdata[own*32 +: 32];
      e_size  = sys.dma_size[own*2 +: 2];
      e_write = sys.dma_write[own];
      e_gnt[own] = 1'b1;
    end
    if (ho || rt) e_write = 1'b0;
    check_eq("bus_addr", sys.bus_addr, e_addr);
    check_eq("bus_wdata", sys.bus_wdata, e_wdata);
    check_eq("bus_size", sys.bus_size, e_size);
    check_eq("bus_write", sys.bus_write, e_write);
    check_eq("dma_gnt", sys.dma_gnt, e_gnt);
    check_eq("dmaActive", sys.dmaActive, (own >= 0) || rt);
    check_eq("gnt_onehot0", $onehot0(sys.dma_gnt), 1'b1);
  endtask

  task automatic randomize_data();
    sys.cpu_addr  = $urandom; sys.cpu_wdata = $urandom;
    sys.cpu_size  = 2'($urandom_range(0, 3)); sys.cpu_write = 1'($urandom_range(0, 1));
    for (int i = 0; i < int'(NUM_CH); i++) begin
      sys.dma_addr[i*32 +: 32]  = $urandom;
      sys.dma_wdata[i*32 +: 32] = $urandom;
      sys.dma_size[i*2 +: 2]    = 2'($urandom_range(0, 3));
      sys.dma_write[i]          = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic quiet();
    sys.dma_req = '0; sys.dma_yield = '0; sys.bus_pause = 1'b0; sys.cpu_preemptable = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1; quiet(); randomize_data();
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    quiet();
    randomize_data();
    do_reset();

    // Reset state and idle CPU passthrough
    sys.cpu_addr = 32'h0300_0010; sys.cpu_write = 1'b1;
    check_model();
    check_eq("idle_addr", sys.bus_addr, 64'h0300_0010);
    check_eq("idle_write", sys.bus_write, 1'b1);
    check_eq("idle_active", sys.dmaActive, 1'b0);
    check_eq("idle_gnt", sys.dma_gnt, 4'b0000);
    tick();

    // Single DMA on channel 2, then release
    sys.dma_req = 4'b0100; sys.dma_write = 4'b0100;
    check_model(); tick();
    check_model();
    check_eq("single_gnt", sys.dma_gnt, 4'b0100);
    check_eq("single_active", sys.dmaActive, 1'b1);
    check_eq("handoff_write", sys.bus_write, 1'b0);
    tick();
    check_model();
    check_eq("single_addr", sys.bus_addr, {32'h0, sys.dma_addr[64 +: 32]});
    sys.dma_req = '0;
    tick(); check_model();
    check_eq("return_gnt", sys.dma_gnt, 4'b0000);
    tick(); check_model();
    check_eq("cpu_back", sys.dmaActive, 1'b0);
    check_eq("cpu_back_addr", sys.bus_addr, {32'h0, sys.cpu_addr});

    // DMA3 preempted by DMA1 only at its yield, then re-granted via RETURN
    sys.dma_req = 4'b1000;
    check_model(); tick(); check_model(); tick();
    sys.dma_req = 4'b1010;
    check_model(); tick();
    check_model(); check_eq("no_preempt", sys.dma_gnt, 4'b1000);
    sys.dma_yield = 4'b1000;
    tick(); sys.dma_yield = '0;
    check_model(); check_eq("preempt_gnt", sys.dma_gnt, 4'b0010);
    tick();
    sys.dma_req = 4'b1000;
    check_model(); tick();
    check_model(); check_eq("ret_active", sys.dmaActive, 1'b1);
    tick();
    check_model(); check_eq("regrant3", sys.dma_gnt, 4'b1000);
    check_eq("regrant_active", sys.dmaActive, 1'b1);
    sys.dma_req = '0; tick(); tick();

    // Same-cycle requests
    sys.dma_req = 4'b1010;
    check_model(); tick();
    check_model(); check_eq("same_cycle", sys.dma_gnt, 4'b0010);
    sys.dma_req = 4'b1000;
    for (int i = 0; i < 4; i++) begin tick(); check_model(); end
    check_eq("same_cycle_2nd", sys.dma_gnt, 4'b1000);

    // Pause freeze while the owner drops its request
    sys.bus_pause = 1'b1; sys.dma_req = '0;
    for (int i = 0; i < 5; i++) begin
      check_model(); check_eq("pause_hold", sys.dma_gnt, 4'b1000); tick();
    end
    sys.bus_pause = 1'b0;
    check_model(); tick();
    check_model(); check_eq("pause_release", sys.dma_gnt, 4'b0000);
    check_eq("pause_ret_active", sys.dmaActive, 1'b1);
    tick();

    // Reset mid-transfer, then a non-preemptable CPU blocks grants
    sys.dma_req = 4'b0001; tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check_model();
    check_eq("rst_gnt", sys.dma_gnt, 4'b0000);
    check_eq("rst_active", sys.dmaActive, 1'b0);
    check_eq("rst_addr", sys.bus_addr, {32'h0, sys.cpu_addr});
    sys.cpu_preemptable = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); check_model(); end
    check_eq("blocked_gnt", sys.dma_gnt, 4'b0000);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      randomize_data();
      reset = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < int'(NUM_CH); i++)
        if ($urandom_range(0, 7) == 0) sys.dma_req[i] = ~sys.dma_req[i];
      sys.dma_yield       = NUM_CH'($urandom_range(0, 15)) & NUM_CH'($urandom_range(0, 15));
      sys.bus_pause       = ($urandom_range(0, 4) == 0);
      sys.cpu_preemptable = 1'($urandom_range(0, 1));
      if (c > 0) check_model();
      tick();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  always @(negedge clock) begin
    if (!reset) assert ($onehot0(sys.dma_gnt));
  end
endmodule

// File: doc/gba_bus_arbiter.md
# gba_bus_arbiter

Owns the shared system bus (`bus_addr`, `bus_wdata`, `bus_size`, `bus_write`, `bus_rdata`, `bus_pause`) in front of `mem_top`. It decides, cycle by cycle, whether the CPU or one of the four DMA channels drives the bus:
- fixed priority DMA0 > DMA1 > DMA2 > DMA3 > CPU;
- ownership changes only at safe boundaries (CPU preemptable, DMA unit boundary, memory not paused).

It replaces the wired sharing of the bus between `cpu_top` and `dma_top`, and produces `dmaActive` for the CPU and the interrupt logic.

## Interface
Parameters
- `NUM_CH`, 4, number of DMA requesters; index 0 has the highest priority.

Ports
- `clock`  in  1  system clock (gba_clk domain).
- `reset`  in  1  synchronous, active-high reset.
- `cpu_addr`  in  32  CPU request address.
- `cpu_wdata`  in  32  CPU write data.
- `cpu_size`  in  2  CPU access size.
- `cpu_write`  in  1  CPU write strobe.
- `cpu_preemptable`  in  1  CPU is at an instruction boundary and may lose the bus.
- `dma_req`  in  NUM_CH  per-channel bus request (level).
- `dma_yield`  in  NUM_CH  per-channel pulse: the current transfer unit has finished, so the channel can be preempted now.
- `dma_addr`  in  32*NUM_CH  per-channel address, channel n in bits [32n+31:32n].
- `dma_wdata`  in  32*NUM_CH  per-channel write data, same packing as `dma_addr`.
- `dma_size`  in  2*NUM_CH  per-channel access size.
- `dma_write`  in  NUM_CH  per-channel write strobe.
- `bus_pause`  in  1  memory wait from `mem_top`.
- `bus_addr`  out  32  muxed address to memory.
- `bus_wdata`  out  32  muxed write data.
- `bus_size`  out  2  muxed access size.
- `bus_write`  out  1  muxed write strobe.
- `dma_gnt`  out  NUM_CH  one-hot grant; all zero when the CPU owns the bus.
- `dmaActive`  out  1  high whenever the bus is not in CPU_OWN.

## Operation
States: CPU_OWN, HANDOFF, DMA_OWN, RETURN. A registered `owner[1:0]` records the granted channel.

- **CPU_OWN:** bus = CPU signals, `dma_gnt` = 0.
  - If any `dma_req` is set, `cpu_preemptable`=1 and `bus_pause`=0: latch the highest-priority requester into `owner`, go to HANDOFF.
- **HANDOFF** (1 cycle):
  - `bus_addr`/`bus_size`/`bus_wdata` = signals of the latched owner; `bus_write` forced 0.
  - `dma_gnt[owner]` = 1 and `dmaActive` = 1.
  - Go to DMA_OWN.
- **DMA_OWN:** bus = signals of `dma[owner]`, `dma_gnt[owner]` = 1. When `bus_pause`=0:
  - `dma_req[owner]`=0: go to RETURN.
  - `dma_yield[owner]`=1 and a higher-priority channel is requesting: `owner` = highest requester, go to HANDOFF.
  - Otherwise stay.
  - While `bus_pause`=1 all decisions are frozen.
- **RETURN** (1 cycle):
  - Bus = CPU signals with `bus_write` forced 0; `dma_gnt` = 0; `dmaActive` = 1.
  - If another `dma_req` is pending and `bus_pause`=0, go to HANDOFF with the new owner (the CPU is not re-granted in between).
  - Otherwise go to CPU_OWN.
- A lower-priority request never preempts; it waits until the owner releases.
- The bus mux is combinational from the registered state/owner. The grant and next-state logic is registered.
- Reset values: state CPU_OWN, `owner` = 0, `dma_gnt` = 0, `dmaActive` = 0, and `bus_*` equal to the CPU inputs.

## Timing
- **CPU → DMA latency:** 2 clocks from the cycle where the request is seen with the conditions met to the first DMA-driven write (HANDOFF, then DMA_OWN).
- **DMA → CPU latency:** 2 clocks from `dma_req[owner]` falling (with `bus_pause`=0) to CPU ownership (RETURN, then CPU_OWN).
- **Request drops in HANDOFF:** if `dma_req[owner]` falls during HANDOFF, the block still enters DMA_OWN, then releases the next cycle.
- **Simultaneous requests:** when several requests rise in the same cycle, the lowest index wins.
- **`dma_yield` and release together:** release has precedence.
- **`bus_pause` held high:** the state, `owner` and `dma_gnt` hold indefinitely; `bus_write` keeps its current muxed value.
- **Reset mid-transfer:** on the next edge the arbiter returns to CPU_OWN with `dma_gnt`=0. Partial DMA units are dropped.
- **Invariant:** `dma_gnt` is always zero or one-hot; this is asserted in the bench.

## Test plan
- **Idle CPU:** `dma_req`=0, CPU drives addr 0x0300_0010 with write=1 → `bus_addr`=0x0300_0010 and `bus_write`=1 on the same cycle; `dmaActive`=0 throughout.
- **Single DMA:** `dma_req`=4'b0100 with `cpu_preemptable`=1 → `dma_gnt`=0100 and `dmaActive`=1 one clock later; `bus_write`=0 in HANDOFF; `bus_addr`=dma2 addr from the second clock. Dropping the request → CPU back on the bus after 2 clocks.
- **Preemption:** DMA3 owns the bus and DMA1 raises its request.
  - No grant change until the cycle after `dma_yield[3]`, then `dma_gnt`=0010.
  - When DMA1 releases → RETURN → DMA3 re-granted without reaching CPU_OWN.
- **Same-cycle requests:** `dma_req`=4'b1010 in the same cycle → DMA1 granted first, then DMA3 granted via RETURN→HANDOFF.
- **Wait freeze:** `bus_pause`=1 for 5 cycles during DMA_OWN while `dma_req` drops → state unchanged for all 5 cycles; RETURN entered on the first cycle with `bus_pause`=0.
- **Reset:** `reset` asserted during DMA_OWN → next cycle `dma_gnt`=0, `dmaActive`=0 and `bus_addr` = CPU addr; `cpu_preemptable`=0 blocks any grant afterwards.
